// File: rtl/vertex_fetch_stream_if.sv
// Vertex output stream from the fetch unit into the graphics pipeline.
// A transfer happens on every clock where valid_out and ready_in are both high.
interface vertex_fetch_stream_if #(
    parameter int IDX_W    = 12,
    parameter int POS_W    = 32,
    parameter int NUM_ATTR = 2
) ();
    logic                      valid_out;
    logic                      ready_in;
    logic [3*POS_W-1:0]        position_out;
    logic [NUM_ATTR*IDX_W-1:0] attr_out;

    modport master (output valid_out, position_out, attr_out, input ready_in);
    modport slave  (input valid_out, position_out, attr_out, output ready_in);
endinterface

// File: rtl/vertex_fetch_stream.sv
// Vertex fetch: index-buffer reads, dependent position reads, credit-limited output FIFO.
// Optional VERTEX_FETCH_DEBUG_EN adds debug_position_id_out carried through the FIFO.
//
// state | meaning
// IDLE  | waiting for start_in
// FETCH | issuing one index read per cycle while credit allows
// DRAIN | no new issues; waiting for in-flight reads and the FIFO to empty
module vertex_fetch_stream #(
    parameter int IDX_W       = 12,
    parameter int ADDR_W      = 16,
    parameter int POS_W       = 32,
    parameter int NUM_ATTR    = 2,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic [ADDR_W-1:0]            base_addr_in,
    input  logic [ADDR_W-1:0]            max_count_in,
    output logic                         busy_out,
    output logic                         done_out,
    output logic [ADDR_W-1:0]            vertex_count_out,
    output logic [ADDR_W-1:0]            index_id_out,
    input  logic [(NUM_ATTR+1)*IDX_W-1:0] index_in,
    output logic [IDX_W-1:0]             position_id_out,
    input  logic [3*POS_W-1:0]           position_in,
`ifdef VERTEX_FETCH_DEBUG_EN
    output logic [IDX_W-1:0]             debug_position_id_out,
`endif
    vertex_fetch_stream_if.master        vtx
);

    localparam int ATTR_W   = NUM_ATTR * IDX_W;
    localparam int POS_BITS = 3 * POS_W;
`ifdef VERTEX_FETCH_DEBUG_EN
    localparam int FIFO_W   = POS_BITS + ATTR_W + IDX_W;
`else
    localparam int FIFO_W   = POS_BITS + ATTR_W;
`endif
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int OCC_W    = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q;
    logic                busy_q, done_q, squash_q;
    logic [ADDR_W-1:0]   addr_q, limit_q, issued_q, count_q, index_id_q;
    logic [MEM_LATENCY:0]   idx_vld_q;
    logic [MEM_LATENCY-1:0] pos_vld_q;
    logic [ATTR_W-1:0]   attr_pipe_q [MEM_LATENCY];
`ifdef VERTEX_FETCH_DEBUG_EN
    logic [IDX_W-1:0]    pid_pipe_q [MEM_LATENCY];
`endif
    logic [CNT_W-1:0]    inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FIFO_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [FIFO_W-1:0]   push_data, head;
    logic [OCC_W-1:0]    occupancy;
    logic                idx_ret, sent_hit, keep, drop, credit_ok, issue_fire, push, pop;

    // Once a sentinel returns, everything behind it in this pass is dropped.
    assign idx_ret    = idx_vld_q[MEM_LATENCY];
    assign sent_hit   = idx_ret && !squash_q && (index_in[IDX_W-1:0] == {IDX_W{1'b1}});
    assign keep       = idx_ret && !squash_q && !sent_hit;
    assign drop       = idx_ret && !keep;
    assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign credit_ok  = occupancy < DEPTH_C;
    assign issue_fire = (state_q == FETCH) && !sent_hit && (issued_q != limit_q) && credit_ok;
    assign push       = pos_vld_q[MEM_LATENCY-1];
    assign pop        = vtx.valid_out && vtx.ready_in;
    assign inflight_d = inflight_q + CNT_W'(issue_fire) - CNT_W'(drop) - CNT_W'(push);
    assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

    assign position_id_out = index_in[ATTR_W +: IDX_W];

`ifdef VERTEX_FETCH_DEBUG_EN
    assign push_data = {pid_pipe_q[MEM_LATENCY-1], position_in, attr_pipe_q[MEM_LATENCY-1]};
    assign debug_position_id_out = head[FIFO_W-1 -: IDX_W];
`else
    assign push_data = {position_in, attr_pipe_q[MEM_LATENCY-1]};
`endif

    assign head             = fifo_q[rd_ptr_q];
    assign vtx.valid_out    = (fifo_cnt_q != '0);
    assign vtx.position_out = head[ATTR_W +: POS_BITS];
    assign vtx.attr_out     = head[ATTR_W-1:0];

    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign vertex_count_out = count_q;
    assign index_id_out     = index_id_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            squash_q   <= 1'b0;
            addr_q     <= '0;
            limit_q    <= '0;
            issued_q   <= '0;
            count_q    <= '0;
            index_id_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (pop) count_q <= count_q + ADDR_W'(1);
            if (sent_hit) squash_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        state_q  <= FETCH;
                        busy_q   <= 1'b1;
                        addr_q   <= base_addr_in;
                        limit_q  <= max_count_in;
                        issued_q <= '0;
                        count_q  <= '0;
                        squash_q <= 1'b0;
                    end
                end
                FETCH: begin
                    if (sent_hit || (issued_q == limit_q)) begin
                        state_q <= DRAIN;
                    end else if (issue_fire) begin
                        index_id_q <= addr_q;
                        addr_q     <= addr_q + ADDR_W'(1);
                        issued_q   <= issued_q + ADDR_W'(1);
                        if ((issued_q + ADDR_W'(1)) == limit_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Index tags line up with index_in; attrs wait MEM_LATENCY for their position.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_vld_q  <= '0;
            pos_vld_q  <= '0;
            inflight_q <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                attr_pipe_q[k] <= '0;
`ifdef VERTEX_FETCH_DEBUG_EN
                pid_pipe_q[k]  <= '0;
`endif
            end
        end else begin
            idx_vld_q      <= {idx_vld_q[MEM_LATENCY-1:0], issue_fire};
            pos_vld_q[0]   <= keep;
            attr_pipe_q[0] <= index_in[ATTR_W-1:0];
`ifdef VERTEX_FETCH_DEBUG_EN
            pid_pipe_q[0]  <= index_in[ATTR_W +: IDX_W];
`endif
            for (int k = 1; k < MEM_LATENCY; k++) begin
                pos_vld_q[k]   <= pos_vld_q[k-1];
                attr_pipe_q[k] <= attr_pipe_q[k-1];
`ifdef VERTEX_FETCH_DEBUG_EN
                pid_pipe_q[k]  <= pid_pipe_q[k-1];
`endif
            end
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_q[k] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule
